// File: rtl/beta_pkg.sv
// Shared types and constants for the Beta pipeline hazard controller.
package beta_pkg;

  typedef enum logic [0:0] {RUN, MEM_WAIT} hz_state_t;

  localparam logic [1:0] BYP_RF  = 2'd0;
  localparam logic [1:0] BYP_ALU = 2'd1;
  localparam logic [1:0] BYP_MEM = 2'd2;
  localparam logic [1:0] BYP_WB  = 2'd3;

  localparam logic [4:0] R31 = 5'd31;

  // A used source that names a pending load destination cannot be bypassed yet.
  function automatic logic load_hit(logic [4:0] src, logic used, logic [4:0] rc, logic ld,
                                    logic we);
    return used && (src != R31) && ld && we && (rc == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Stage-field observation and pipeline-control strobes between datapath and hazard controller.
interface pipe_hazard_ctl_if;
  logic [4:0] rf_ra;
  logic [4:0] rf_rb;
  logic       rf_ra_used;
  logic       rf_rb_used;
  logic       rf_br_taken;
  logic [4:0] alu_rc;
  logic [4:0] mem_rc;
  logic [4:0] wb_rc;
  logic       alu_we;
  logic       mem_we;
  logic       wb_we;
  logic       alu_ld;
  logic       mem_ld;
  logic       mem_req;
  logic       mem_ready;
  logic       stall_if;
  logic       stall_rf;
  logic       stall_alu;
  logic       stall_mem;
  logic       bubble_alu;
  logic       bubble_wb;
  logic       annul_if;
  logic [1:0] byp_a_sel;
  logic [1:0] byp_b_sel;

  modport master (
    output rf_ra, rf_rb, rf_ra_used, rf_rb_used, rf_br_taken,
    output alu_rc, mem_rc, wb_rc, alu_we, mem_we, wb_we, alu_ld, mem_ld,
    output mem_req, mem_ready,
    input  stall_if, stall_rf, stall_alu, stall_mem, bubble_alu, bubble_wb, annul_if,
    input  byp_a_sel, byp_b_sel
  );

  modport slave (
    input  rf_ra, rf_rb, rf_ra_used, rf_rb_used, rf_br_taken,
    input  alu_rc, mem_rc, wb_rc, alu_we, mem_we, wb_we, alu_ld, mem_ld,
    input  mem_req, mem_ready,
    output stall_if, stall_rf, stall_alu, stall_mem, bubble_alu, bubble_wb, annul_if,
    output byp_a_sel, byp_b_sel
  );
endinterface

// File: rtl/byp_sel.sv
// Operand bypass select for one RF-stage source: youngest writing stage wins.
module byp_sel
  import beta_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] alu_rc,
  input  logic       alu_we,
  input  logic [4:0] mem_rc,
  input  logic       mem_we,
  input  logic [4:0] wb_rc,
  input  logic       wb_we,
  output logic [1:0] sel
);

  always_comb begin
    sel = BYP_RF;
    // R31 reads as zero, so it is never bypassed.
    if (src != R31) begin
      if (alu_we && (alu_rc == src)) begin
        sel = BYP_ALU;
      end else if (mem_we && (mem_rc == src)) begin
        sel = BYP_MEM;
      end else if (wb_we && (wb_rc == src)) begin
        sel = BYP_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Central hazard controller for the 5-stage Beta pipeline: memory-wait sequencing,
// load-use interlock, branch annul, operand bypass selection and performance counters.
module pipe_hazard_ctl
  import beta_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctl_if.slave bus,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] annul_cnt
);

  localparam int unsigned    WaitW   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  hz_state_t        state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, annul_cnt_q;

  logic       mem_wait;
  logic       load_use;
  logic [1:0] sel_a, sel_b;

  assign mem_wait = bus.mem_req & ~bus.mem_ready;

  assign load_use =
      load_hit(bus.rf_ra, bus.rf_ra_used, bus.alu_rc, bus.alu_ld, bus.alu_we) |
      load_hit(bus.rf_ra, bus.rf_ra_used, bus.mem_rc, bus.mem_ld, bus.mem_we) |
      load_hit(bus.rf_rb, bus.rf_rb_used, bus.alu_rc, bus.alu_ld, bus.alu_we) |
      load_hit(bus.rf_rb, bus.rf_rb_used, bus.mem_rc, bus.mem_ld, bus.mem_we);

  byp_sel u_byp_a (
    .src    (bus.rf_ra),
    .alu_rc (bus.alu_rc),
    .alu_we (bus.alu_we),
    .mem_rc (bus.mem_rc),
    .mem_we (bus.mem_we),
    .wb_rc  (bus.wb_rc),
    .wb_we  (bus.wb_we),
    .sel    (sel_a)
  );

  byp_sel u_byp_b (
    .src    (bus.rf_rb),
    .alu_rc (bus.alu_rc),
    .alu_we (bus.alu_we),
    .mem_rc (bus.mem_rc),
    .mem_we (bus.mem_we),
    .wb_rc  (bus.wb_rc),
    .wb_we  (bus.wb_we),
    .sel    (sel_b)
  );

  // Priority: memory wait freezes everything, then load-use interlock, then annul.
  always_comb begin
    bus.stall_if   = 1'b0;
    bus.stall_rf   = 1'b0;
    bus.stall_alu  = 1'b0;
    bus.stall_mem  = 1'b0;
    bus.bubble_alu = 1'b0;
    bus.bubble_wb  = 1'b0;
    bus.annul_if   = 1'b0;
    bus.byp_a_sel  = BYP_RF;
    bus.byp_b_sel  = BYP_RF;
    if (!rst) begin
      bus.byp_a_sel = sel_a;
      bus.byp_b_sel = sel_b;
      if (mem_wait) begin
        bus.stall_if  = 1'b1;
        bus.stall_rf  = 1'b1;
        bus.stall_alu = 1'b1;
        bus.stall_mem = 1'b1;
        bus.bubble_wb = 1'b1;
      end else if (load_use) begin
        bus.stall_if   = 1'b1;
        bus.stall_rf   = 1'b1;
        bus.bubble_alu = 1'b1;
      end else begin
        bus.annul_if = bus.rf_br_taken;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    unique case (state_q)
      RUN: begin
        if (mem_wait) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d = RUN;
        end else if (wait_q != WaitMax) begin
          wait_d = wait_q + 1'b1;
        end
      end
    endcase
    if (state_d == RUN) wait_d = '0;
    if (wait_d == WaitMax) mem_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      annul_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_q + CNT_W'(bus.stall_if);
      annul_cnt_q <= annul_cnt_q + CNT_W'(bus.annul_if);
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign annul_cnt = annul_cnt_q;

endmodule
